microwave_oven_ctrl: RTL and testbench

MICROWAVE_OVEN_CTRL -- requirements
Module: microwave_oven_ctrl

---
 rtl/microwave_oven_ctrl.sv | 94 +++++++++
 tb/tb_microwave_oven_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/microwave_oven_ctrl.sv
// Microwave oven controller: keypad load, countdown cook, pause/resume, end beep.
// Every output is a flop; the next values are decided in one FSM process.
module microwave_oven_ctrl #(
  parameter int MAX_TIME   = 999,
  parameter int BEEP_TICKS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       start,
  input  logic       stop_clear,
  input  logic       door_closed,
  input  logic       load,
  input  logic [9:0] load_value,
  output logic [9:0] time_left,
  output logic       magnetron_on,
  output logic       mux_sel,
  output logic       done_beep,
  output logic [1:0] state
);

  localparam int          CW    = $clog2(BEEP_TICKS + 1);
  localparam logic [9:0]  MAX_T = 10'(MAX_TIME);
  localparam logic [CW-1:0] LAST_BEEP = CW'(BEEP_TICKS - 1);

  typedef enum logic [1:0] {IDLE = 2'b00, COOK = 2'b01, PAUSE = 2'b10, DONE = 2'b11} st_t;

  st_t          st;
  logic [CW-1:0] beep_cnt;

  assign state = st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st           <= IDLE;
      time_left    <= '0;
      magnetron_on <= 1'b0;
      mux_sel      <= 1'b0;
      done_beep    <= 1'b0;
      beep_cnt     <= '0;
    end else begin
      case (st)
        IDLE: begin
          // A load wins over a simultaneous start.
          if (load)
            time_left <= (load_value > MAX_T) ? MAX_T : load_value;
          else if (start && door_closed && time_left != '0) begin
            st           <= COOK;
            magnetron_on <= 1'b1;
            mux_sel      <= 1'b1;
          end
        end
        COOK: begin
          // Door/stop pre-empts a same-cycle tick so no second is lost.
          if (stop_clear || !door_closed) begin
            st           <= PAUSE;
            magnetron_on <= 1'b0;
          end else if (tick_1hz) begin
            if (time_left > 10'd1)
              time_left <= time_left - 10'd1;
            else begin
              time_left    <= '0;
              st           <= DONE;
              magnetron_on <= 1'b0;
              done_beep    <= 1'b1;
              beep_cnt     <= '0;
            end
          end
        end
        PAUSE: begin
          if (stop_clear) begin
            st        <= IDLE;
            time_left <= '0;
            mux_sel   <= 1'b0;
          end else if (start && door_closed) begin
            st           <= COOK;
            magnetron_on <= 1'b1;
          end
        end
        DONE: begin
          if (stop_clear || !door_closed || (tick_1hz && beep_cnt == LAST_BEEP)) begin
            st        <= IDLE;
            mux_sel   <= 1'b0;
            done_beep <= 1'b0;
            beep_cnt  <= '0;
          end else if (tick_1hz)
            beep_cnt <= beep_cnt + 1'b1;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_microwave_oven_ctrl.sv
// Bench for microwave_oven_ctrl: directed vector table, corner sequences, random vs model.
module tb_microwave_oven_ctrl;

  localparam int MAXT = 999;
  localparam int BEEPS = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_1hz, start, stop_clear, door_closed, load;
  logic [9:0] load_value;
  logic [9:0] time_left;
  logic       magnetron_on, mux_sel, done_beep;
  logic [1:0] state;

  microwave_oven_ctrl #(.MAX_TIME(MAXT), .BEEP_TICKS(BEEPS)) dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .start(start),
    .stop_clear(stop_clear), .door_closed(door_closed), .load(load),
    .load_value(load_value), .time_left(time_left), .magnetron_on(magnetron_on),
    .mux_sel(mux_sel), .done_beep(done_beep), .state(state)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Reference model: mode 0=idle 1=cooking 2=paused 3=beeping.
  int m_mode, m_tl, m_beeps;

  typedef struct {
    logic       st, sp, dr, tk, ld;
    logic [9:0] lv;
    int         e_st, e_tl;
    logic       e_mag, e_mux, e_beep;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic st, logic sp, logic dr, logic tk, logic ld, int lv,
                              int est, int etl, logic mag, logic mux, logic bp);
    vec_t v;
    v.st = st; v.sp = sp; v.dr = dr; v.tk = tk; v.ld = ld; v.lv = 10'(lv);
    v.e_st = est; v.e_tl = etl; v.e_mag = mag; v.e_mux = mux; v.e_beep = bp;
    return v;
  endfunction

  function automatic void model_reset();
    m_mode = 0; m_tl = 0; m_beeps = 0;
  endfunction

  function automatic void model_step(logic st, logic sp, logic dr, logic tk, logic ld, int lv);
    case (m_mode)
      0: if (ld) m_tl = (lv < MAXT) ? lv : MAXT;
         else if (st && dr && m_tl > 0) m_mode = 1;
      1: if (sp || !dr) m_mode = 2;
         else if (tk) begin
           m_tl = m_tl - 1;
           if (m_tl == 0) begin m_mode = 3; m_beeps = 0; end
         end
      2: if (sp) begin m_mode = 0; m_tl = 0; end
         else if (st && dr) m_mode = 1;
      default: if (sp || !dr) m_mode = 0;
         else if (tk) begin
           m_beeps++;
           if (m_beeps == BEEPS) m_mode = 0;
         end
    endcase
  endfunction

  task automatic check(string name, int est, int etl, logic emag, logic emux, logic ebeep);
    nvec++;
    if (int'(state) != est || int'(time_left) != etl || magnetron_on !== emag ||
        mux_sel !== emux || done_beep !== ebeep) begin
      nerr++;
      $display("FAIL %s: got st=%0d tl=%0d mag=%b mux=%b beep=%b, want st=%0d tl=%0d mag=%b mux=%b beep=%b",
               name, state, time_left, magnetron_on, mux_sel, done_beep, est, etl, emag, emux, ebeep);
    end
  endtask

  task automatic check_model(string name);
    check(name, m_mode, m_tl, m_mode == 1, m_mode != 0, m_mode == 3);
  endtask

  // Drive at negedge, clock once, sample at next negedge.
  task automatic apply(logic st, logic sp, logic dr, logic tk, logic ld, int lv);
    start = st; stop_clear = sp; door_closed = dr; tick_1hz = tk; load = ld;
    load_value = 10'(lv);
    @(posedge clk);
    model_step(st, sp, dr, tk, ld, lv);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    {tick_1hz, start, stop_clear, load} = '0;
    door_closed = 1'b1; load_value = '0;
    model_reset();
    #1;
    check("async_reset", 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check("held_reset", 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    //          st sp dr tk ld  lv     st  tl mag mux beep
    tbl.push_back(mk(0,0,1,0,1,    5,  0,   5, 0,0,0)); // load 5
    tbl.push_back(mk(1,0,1,0,0,    0,  1,   5, 1,1,0)); // start
    tbl.push_back(mk(0,0,1,1,0,    0,  1,   4, 1,1,0));
    tbl.push_back(mk(0,0,1,1,0,    0,  1,   3, 1,1,0));
    tbl.push_back(mk(0,0,1,1,0,    0,  1,   2, 1,1,0));
    tbl.push_back(mk(0,0,1,1,0,    0,  1,   1, 1,1,0));
    tbl.push_back(mk(0,0,1,1,0,    0,  3,   0, 0,1,1)); // done
    tbl.push_back(mk(0,0,1,0,0,    0,  3,   0, 0,1,1));
    tbl.push_back(mk(0,0,1,1,0,    0,  3,   0, 0,1,1)); // beep tick 1
    tbl.push_back(mk(0,0,1,1,0,    0,  3,   0, 0,1,1)); // beep tick 2
    tbl.push_back(mk(0,0,1,1,0,    0,  0,   0, 0,0,0)); // beep tick 3 -> idle
    tbl.push_back(mk(0,0,1,0,1, 1023,  0, 999, 0,0,0)); // clamp
    tbl.push_back(mk(0,0,1,0,1,  999,  0, 999, 0,0,0)); // exact max
    tbl.push_back(mk(0,0,1,0,1,    0,  0,   0, 0,0,0));
    tbl.push_back(mk(1,0,1,0,0,    0,  0,   0, 0,0,0)); // start with 0
    tbl.push_back(mk(0,0,1,0,1,    7,  0,   7, 0,0,0));
    tbl.push_back(mk(1,0,1,0,0,    0,  1,   7, 1,1,0));
    tbl.push_back(mk(0,0,0,1,0,    0,  2,   7, 0,1,0)); // door open + tick
    tbl.push_back(mk(1,0,1,0,0,    0,  1,   7, 1,1,0)); // resume
    tbl.push_back(mk(0,1,1,0,0,    0,  2,   7, 0,1,0)); // stop -> pause
    tbl.push_back(mk(1,1,1,0,0,    0,  0,   0, 0,0,0)); // stop beats start
    tbl.push_back(mk(1,0,1,0,1,    3,  0,   3, 0,0,0)); // load+start: load only
    tbl.push_back(mk(1,0,0,0,0,    0,  0,   3, 0,0,0)); // door open start
    tbl.push_back(mk(1,0,1,0,0,    0,  1,   3, 1,1,0));
    tbl.push_back(mk(0,0,1,0,1,    9,  1,   3, 1,1,0)); // load ignored
    tbl.push_back(mk(0,0,1,1,0,    0,  1,   2, 1,1,0));
    tbl.push_back(mk(0,1,1,0,0,    0,  2,   2, 0,1,0));
    tbl.push_back(mk(0,0,1,1,0,    0,  2,   2, 0,1,0)); // tick in pause
    tbl.push_back(mk(1,0,0,0,0,    0,  2,   2, 0,1,0)); // door open resume
    tbl.push_back(mk(0,0,1,0,1,    8,  2,   2, 0,1,0)); // load in pause
    tbl.push_back(mk(1,0,1,0,0,    0,  1,   2, 1,1,0));
    tbl.push_back(mk(0,0,1,1,0,    0,  1,   1, 1,1,0));
    tbl.push_back(mk(0,0,1,1,0,    0,  3,   0, 0,1,1));
    tbl.push_back(mk(0,0,1,1,0,    0,  3,   0, 0,1,1));
    tbl.push_back(mk(0,0,0,0,0,    0,  0,   0, 0,0,0)); // door aborts beep
    tbl.push_back(mk(0,0,1,0,1,    2,  0,   2, 0,0,0));
    tbl.push_back(mk(1,0,1,0,0,    0,  1,   2, 1,1,0));
    tbl.push_back(mk(0,0,1,1,0,    0,  1,   1, 1,1,0));
    tbl.push_back(mk(0,0,1,1,0,    0,  3,   0, 0,1,1));
    tbl.push_back(mk(0,1,1,0,0,    0,  0,   0, 0,0,0)); // stop aborts beep

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].st, tbl[i].sp, tbl[i].dr, tbl[i].tk, tbl[i].ld, int'(tbl[i].lv));
      check($sformatf("vec%0d", i), tbl[i].e_st, tbl[i].e_tl, tbl[i].e_mag, tbl[i].e_mux, tbl[i].e_beep);
    end

    // Reset mid-cook, between clock edges.
    apply(0,0,1,0,1,42);
    apply(1,0,1,0,0,0);
    apply(0,0,1,0,0,0);
    check("cook42", 1, 42, 1, 1, 0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("midcook_reset", 0, 0, 0, 0, 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    apply(1,0,1,0,0,0);
    check("post_reset_start", 0, 0, 0, 0, 0);
    apply(1,0,1,1,0,0);
    check("post_reset_start2", 0, 0, 0, 0, 0);

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      logic rst_, st, sp, dr, tk, ld;
      int lv;
      st = ($urandom_range(3) == 0);
      sp = ($urandom_range(11) == 0);
      dr = ($urandom_range(11) != 0);
      tk = ($urandom_range(2) == 0);
      ld = ($urandom_range(7) == 0);
      lv = ($urandom_range(3) == 0) ? int'($urandom_range(1023)) : int'($urandom_range(6));
      rst_ = ($urandom_range(499) == 0);
      if (rst_) begin
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_model("rand_reset");
        #1 rst_n = 1'b1;
        @(negedge clk);
      end
      apply(st, sp, dr, tk, ld, lv);
      check_model($sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
